alu_muldiv: RTL and testbench
=============================

ALU_MULDIV -- requirements
Module: alu_muldiv

Interface
REQ-001 SHALL have parameter XLEN, default 32: operand/result width, legal values 8..64, even.
REQ-002 SHALL have port clk, input, 1: single clock, all state updates on the rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have port in_valid, input, 1: operation request.
REQ-005 SHALL have port in_ready, output, 1: block can accept a request.
REQ-006 SHALL have port op, input, 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have port operand_a, input, XLEN: multiplicand/dividend.
REQ-008 SHALL have port operand_b, input, XLEN: multiplier/divisor.
REQ-009 SHALL have port kill, input, 1: abort the in-flight operation.
REQ-010 SHALL have port out_valid, output, 1: result available.
REQ-011 SHALL have port out_ready, input, 1: consumer accepts the result.
REQ-012 SHALL have port result, output, XLEN: operation result.
REQ-013 SHALL have ports Z, N, V, DZ, output, 1 each: result zero, result MSB, signed-division overflow, divide-by-zero.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-015 SHALL accept a request on an edge where in_valid & in_ready, latching op, operand_a and operand_b; input changes after acceptance SHALL have no effect.
REQ-016 SHALL take a normal request from IDLE to BUSY and run exactly XLEN iterations (counter 0..XLEN-1), then go to DONE.
REQ-017 SHALL give normal latency as follows: request accepted at edge N -> out_valid = 1 after edge N+XLEN+1.
REQ-018 SHALL use radix-2 shift-add for multiply, with signed/unsigned operand handling per op (MULHSU: a signed, b unsigned), over a 2*XLEN-bit product; MUL returns the low XLEN bits and MULH/MULHSU/MULHU return the high XLEN bits.
REQ-019 SHALL use restoring division on operand magnitudes for DIV/REM, with quotient sign = sign(a) XOR sign(b) and remainder sign = sign(a) (round toward zero).
REQ-020 SHALL handle divisor = 0 as a special case: go IDLE->DONE directly (out_valid after edge N+1), quotient all-ones, remainder = operand_a, DZ = 1.
REQ-021 SHALL handle signed overflow (DIV/REM, a = most-negative, b = -1) as a special case: go IDLE->DONE directly, quotient = a, remainder = 0, V = 1.
REQ-022 SHALL set V and DZ only in the special cases above and drive them 0 otherwise.
REQ-023 SHALL hold result and flags stable in DONE while out_valid = 1 and out_ready = 0.
REQ-024 SHALL leave DONE for IDLE on an edge where out_ready = 1; the next request can then be accepted no earlier than the following edge.
REQ-025 SHALL return from BUSY or DONE to IDLE on the next edge when kill = 1, with no out_valid pulse for the aborted operation.
REQ-026 SHALL give kill priority over completion and over out_ready when they coincide.
REQ-027 SHALL ignore kill in IDLE; a request presented together with kill in IDLE SHALL NOT be accepted.
REQ-028 SHALL drive Z = (result == 0) and N = result[XLEN-1], valid while out_valid = 1.
REQ-029 SHALL drive result, Z, N, V and DZ to 0 whenever out_valid = 0.

Reset
REQ-030 SHALL, on rst_n = 0 at any time including mid-operation, immediately force state IDLE, iteration counter 0, in_ready = 1, out_valid = 0, and result, Z, N, V, DZ all 0.
REQ-031 SHALL, after rst_n deasserts, accept a request on the first rising edge on which in_valid = 1.

Verification (XLEN = 32)
REQ-032 SHALL pass: MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, N = 1, out_valid after exactly 33 edges; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-033 SHALL pass: DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM 0xFFFFFFF9 / 2 -> 0xFFFFFFFF; DIVU 100 / 7 -> 14; REMU 100 / 7 -> 2, Z = 0.
REQ-034 SHALL pass: DIV 5 / 0 -> 0xFFFFFFFF with DZ = 1; REM 5 / 0 -> 5; out_valid after edge N+1; 0x80000000 / 0xFFFFFFFF -> DIV 0x80000000, REM 0 with Z = 1, V = 1.
REQ-035 SHALL pass: out_ready held 0 for 5 cycles after out_valid -> result and flags stable and in_ready = 0 throughout; out_ready = 1 -> IDLE next edge.
REQ-036 SHALL pass: kill at iteration 10 -> IDLE next edge, no out_valid; the following MUL 3 x 4 -> 12 is correct.
REQ-037 SHALL pass: rst_n pulsed low at iteration 20 -> all outputs 0 and in_ready = 1 immediately; a new DIVU 9 / 3 -> 3 is correct.

Source files
------------

// File: rtl/alu_muldiv.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring divide,
// with one request in flight, valid/ready handshakes, kill and result flags.
module alu_muldiv #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            Z,
    output logic            N,
    output logic            V,
    output logic            DZ
);

    localparam int CNT_W = $clog2(XLEN);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic            last_q,  last_d;
    logic [2:0]      op_q,    op_d;
    logic            neg_q,   neg_d;
    logic [XLEN-1:0] hi_q,    hi_d;
    logic [XLEN-1:0] lo_q,    lo_d;
    logic [XLEN-1:0] mcand_q, mcand_d;
    logic [XLEN-1:0] res_q,   res_d;
    logic            v_q,     v_d;
    logic            dz_q,    dz_d;

    // Request decode: signedness, magnitudes and the two division special cases.
    logic            a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_zero, div_ovf, accept;

    assign a_signed = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    assign b_signed = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign sign_a   = a_signed & operand_a[XLEN-1];
    assign sign_b   = b_signed & operand_b[XLEN-1];
    assign abs_a    = sign_a ? -operand_a : operand_a;
    assign abs_b    = sign_b ? -operand_b : operand_b;
    assign div_zero = op[2] && (operand_b == '0);
    assign div_ovf  = op[2] && !op[0] && (operand_a == MOST_NEG) && (operand_b == '1);
    assign accept   = in_valid && in_ready && !kill;

    // One multiply step: conditionally add the multiplicand, then shift {hi,lo} right.
    logic [XLEN:0]   mul_sum, mul_add;
    logic [XLEN-1:0] mul_hi_nx, mul_lo_nx;

    assign mul_sum   = {1'b0, hi_q} + {1'b0, mcand_q};
    assign mul_add   = lo_q[0] ? mul_sum : {1'b0, hi_q};
    assign mul_hi_nx = mul_add[XLEN:1];
    assign mul_lo_nx = {mul_add[0], lo_q[XLEN-1:1]};

    // One restoring-divide step; the partial remainder is always below the divisor,
    // so the top bit of the trial difference is a reliable borrow.
    logic [XLEN:0]   div_shift, div_trial;
    logic            div_fits;
    logic [XLEN-1:0] div_hi_nx, div_lo_nx;

    assign div_shift = {hi_q, lo_q[XLEN-1]};
    assign div_trial = div_shift - {1'b0, mcand_q};
    assign div_fits  = !div_trial[XLEN];
    assign div_hi_nx = div_fits ? div_trial[XLEN-1:0] : div_shift[XLEN-1:0];
    assign div_lo_nx = {lo_q[XLEN-2:0], div_fits};

    // Sign correction and result selection after the last iteration.
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   mul_res, div_raw, div_res, fin_res;

    assign prod    = {hi_q, lo_q};
    assign prod_s  = neg_q ? -prod : prod;
    assign mul_res = (op_q == OP_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    assign div_raw = op_q[1] ? hi_q : lo_q;
    assign div_res = neg_q ? -div_raw : div_raw;
    assign fin_res = op_q[2] ? div_res : mul_res;

    always_comb begin
        // NOTE: every next-state signal gets a default here so no path leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        op_d    = op_q;
        neg_d   = neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        mcand_d = mcand_q;
        res_d   = res_q;
        v_d     = v_q;
        dz_d    = dz_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d = op;
                    v_d  = 1'b0;
                    dz_d = 1'b0;
                    if (div_zero) begin
                        res_d   = op[1] ? operand_a : '1;
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else if (div_ovf) begin
                        res_d   = op[1] ? '0 : operand_a;
                        v_d     = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        cnt_d   = '0;
                        last_d  = 1'b0;
                        neg_d   = (op[2] && op[1]) ? sign_a : (sign_a ^ sign_b);
                        hi_d    = '0;
                        lo_d    = op[2] ? abs_a : abs_b;
                        mcand_d = op[2] ? abs_b : abs_a;
                        state_d = S_BUSY;
                    end
                end
            end
            S_BUSY: begin
                if (kill) begin
                    cnt_d   = '0;
                    last_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (last_q) begin
                    res_d   = fin_res;
                    last_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    hi_d = op_q[2] ? div_hi_nx : mul_hi_nx;
                    lo_d = op_q[2] ? div_lo_nx : mul_lo_nx;
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        cnt_d  = '0;
                        last_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                if (kill || out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b0;
            op_q    <= '0;
            neg_q   <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            mcand_q <= '0;
            res_q   <= '0;
            v_q     <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mcand_q <= mcand_d;
            res_q   <= res_d;
            v_q     <= v_d;
            dz_q    <= dz_d;
        end
    end

    // Outputs are gated by out_valid so reset or idle forces them to zero at once.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = out_valid ? res_q : '0;
    assign Z         = out_valid && (res_q == '0);
    assign N         = out_valid && res_q[XLEN-1];
    assign V         = out_valid && v_q;
    assign DZ        = out_valid && dz_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv at XLEN = 32: arithmetic vectors,
// latency, special cases, back-pressure, kill and asynchronous reset.
module tb_alu_muldiv;

    localparam int XLEN = 32;
    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
    localparam int NORM_LAT = XLEN + 1;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2:0]      op = '0;
    logic [XLEN-1:0] operand_a = '0;
    logic [XLEN-1:0] operand_b = '0;
    logic            kill = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] result;
    logic            Z, N, V, DZ;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_muldiv #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .Z         (Z),
        .N         (N),
        .V         (V),
        .DZ        (DZ)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present a request for one edge, then scramble the inputs to show they are ignored.
    task automatic issue(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        @(negedge clk);
        in_valid  = 1'b1;
        op        = o;
        operand_a = a;
        operand_b = b;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        op        = ~o;
        operand_a = $urandom;
        operand_b = $urandom;
    endtask

    // Count edges after acceptance until out_valid is seen; bounded.
    task automatic wait_valid(input string tag, input int exp_lat);
        int n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (!out_valid && n < 100);
        check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    endtask

    task automatic check_out(input string tag, input logic [XLEN-1:0] exp_res,
                             input logic [3:0] exp_znvdz);
        check({tag, "_res"}, 64'(result), 64'(exp_res));
        check({tag, "_flags"}, 64'({Z, N, V, DZ}), 64'(exp_znvdz));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_idle"}, 64'({in_ready, out_valid}), 64'(2'b10));
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [XLEN-1:0] a,
                          input logic [XLEN-1:0] b, input logic [XLEN-1:0] exp_res,
                          input logic [3:0] exp_znvdz, input int exp_lat);
        issue(o, a, b);
        wait_valid(tag, exp_lat);
        check_out(tag, exp_res, exp_znvdz);
        release_out(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_outs", 64'({out_valid, result, Z, N, V, DZ}), 64'd0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        // Multiply vectors: {Z,N,V,DZ} expected flags
        run_op("mul",    MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 4'b0100, NORM_LAT);
        run_op("mulhu",  MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b0100, NORM_LAT);
        run_op("mulh",   MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 4'b0000, NORM_LAT);
        run_op("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b0100, NORM_LAT);
        run_op("mul0",   MUL,    32'd0,        32'd12345,     32'd0,         4'b1000, NORM_LAT);

        // Divide vectors
        run_op("div",  DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 4'b0100, NORM_LAT);
        run_op("rem",  REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 4'b0100, NORM_LAT);
        run_op("divu", DIVU, 32'd100,       32'd7, 32'd14,        4'b0000, NORM_LAT);
        run_op("remu", REMU, 32'd100,       32'd7, 32'd2,         4'b0000, NORM_LAT);

        // Special cases finish one edge after acceptance
        run_op("div_dz",  DIV, 32'd5,         32'd0,         32'hFFFF_FFFF, 4'b0101, 1);
        run_op("rem_dz",  REM, 32'd5,         32'd0,         32'd5,         4'b0001, 1);
        run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 4'b0110, 1);
        run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         4'b1010, 1);

        // Back-pressure: result and flags held, in_ready low, for 5 cycles
        issue(DIVU, 32'd100, 32'd7);
        wait_valid("stall", NORM_LAT);
        for (int i = 0; i < 5; i++) begin
            check("stall_res", 64'(result), 64'd14);
            check("stall_sig", 64'({in_ready, out_valid, Z, N, V, DZ}), 64'(6'b010000));
            @(posedge clk);
            @(negedge clk);
        end
        release_out("stall");
        check("idle_res_zero", 64'(result), 64'd0);

        // Kill at iteration 10, then a clean MUL
        issue(MUL, 32'h0001_2345, 32'h0000_6789);
        repeat (10) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        check("kill_idle", 64'({in_ready, out_valid}), 64'(2'b10));
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("kill_no_valid", 64'(seen), 64'd0);
        run_op("mul_after_kill", MUL, 32'd3, 32'd4, 32'd12, 4'b0000, NORM_LAT);

        // Kill on the completion edge wins over completion
        issue(MUL, 32'd5, 32'd6);
        repeat (XLEN) @(posedge clk);
        #1 kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        check("kill_done_edge", 64'({in_ready, out_valid}), 64'(2'b10));

        // Request together with kill in IDLE is not accepted
        @(negedge clk);
        in_valid  = 1'b1;
        kill      = 1'b1;
        op        = MUL;
        operand_a = 32'd9;
        operand_b = 32'd9;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        kill     = 1'b0;
        check("kill_idle_reject", 64'(in_ready), 64'd1);

        // Reset asserted mid-operation at iteration 20
        issue(DIVU, 32'h0000_FFFF, 32'd7);
        repeat (20) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_busy_ready", 64'(in_ready), 64'd1);
        check("rst_busy_outs", 64'({out_valid, result, Z, N, V, DZ}), 64'd0);
        #4 rst_n = 1'b1;
        run_op("divu_after_rst", DIVU, 32'd9, 32'd3, 32'd3, 4'b0000, NORM_LAT);

        // Reset asserted while a result is waiting
        issue(MUL, 32'd7, 32'hFFFF_FFFD);
        wait_valid("rst_done", NORM_LAT);
        #2 rst_n = 1'b0;
        #1;
        check("rst_done_outs", 64'({in_ready, out_valid, result, Z, N, V, DZ}), 64'(38'h1 << 37));
        #3 rst_n = 1'b1;
        run_op("mul_after_rst", MUL, 32'd3, 32'd4, 32'd12, 4'b0000, NORM_LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
